// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch unit.
// Holds the default operand/register-address widths and the FSM state encoding.
package operand_fetch_unit_pkg;

  localparam int unsigned OFU_DATA_WIDTH     = 32;
  localparam int unsigned OFU_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_WRITE = 2'd3
  } ofu_state_e;

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Bus bundle between the operand fetch unit and its neighbours.
// Signals:
//   request  : req_valid/req_ready, rs_addr, rt_addr
//   operands : op_valid/op_ready, op_a, op_b
//   writeback: wb_valid/wb_ready, wb_addr, wb_data
//   regfile  : rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w,
//              rf_data_r1, rf_data_r2
// The slave modport is the fetch unit; the master modport is its environment.
interface operand_fetch_unit_if
  import operand_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = OFU_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = OFU_REG_ADDR_WIDTH
) ();

  logic                      req_valid;
  logic                      req_ready;
  logic [REG_ADDR_WIDTH-1:0] rs_addr;
  logic [REG_ADDR_WIDTH-1:0] rt_addr;

  logic                      op_valid;
  logic                      op_ready;
  logic [DATA_WIDTH-1:0]     op_a;
  logic [DATA_WIDTH-1:0]     op_b;

  logic                      wb_valid;
  logic                      wb_ready;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]     wb_data;

  logic                      rf_read;
  logic                      rf_write;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r1;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r2;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_w;
  logic [DATA_WIDTH-1:0]     rf_data_w;
  logic [DATA_WIDTH-1:0]     rf_data_r1;
  logic [DATA_WIDTH-1:0]     rf_data_r2;

  modport slave (
    input  req_valid, rs_addr, rt_addr, op_ready, wb_valid, wb_addr, wb_data,
           rf_data_r1, rf_data_r2,
    output req_ready, op_valid, op_a, op_b, wb_ready, rf_read, rf_write,
           rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
  );

  modport master (
    output req_valid, rs_addr, rt_addr, op_ready, wb_valid, wb_addr, wb_data,
           rf_data_r1, rf_data_r2,
    input  req_ready, op_valid, op_a, op_b, wb_ready, rf_read, rf_write,
           rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w
  );

endinterface

// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: arbitrates between write-back and operand-fetch requests
// onto an external register file, one port access per cycle.
// Ports:
//   CLK : clock, all state on posedge
//   RST : asynchronous active-high reset
//   bus : operand_fetch_unit_if.slave (request, operand, write-back, regfile)
// Write-back wins over a simultaneous request, so a request issued alongside a
// write to the same register returns the freshly written value.
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = OFU_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = OFU_REG_ADDR_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  operand_fetch_unit_if.slave  bus
);

  ofu_state_e                state;
  ofu_state_e                state_next;

  logic [REG_ADDR_WIDTH-1:0] rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;
  logic [DATA_WIDTH-1:0]     op_a_q;
  logic [DATA_WIDTH-1:0]     op_b_q;

  logic                      req_ready_c;
  logic                      wb_ready_c;
  logic                      op_valid_c;
  logic                      rf_read_c;
  logic                      rf_write_c;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_w_c;
  logic [DATA_WIDTH-1:0]     rf_data_w_c;

  // State register, request address latch and operand capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      rs_q   <= '0;
      rt_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      state <= state_next;
      if (bus.req_valid && req_ready_c) begin
        rs_q <= bus.rs_addr;
        rt_q <= bus.rt_addr;
      end
      // Operands only ever change at the end of the single READ cycle.
      if (state == ST_READ) begin
        op_a_q <= bus.rf_data_r1;
        op_b_q <= bus.rf_data_r2;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    wb_ready_c  = 1'b0;
    op_valid_c  = 1'b0;
    rf_read_c   = 1'b0;
    rf_write_c  = 1'b0;
    rf_addr_w_c = '0;
    rf_data_w_c = '0;
    unique case (state)
      ST_IDLE: begin
        // A pending write-back blocks request acceptance this cycle.
        req_ready_c = !bus.wb_valid && !RST;
        if (bus.wb_valid) begin
          state_next = ST_WRITE;
        end else if (bus.req_valid) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        rf_read_c  = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        op_valid_c = 1'b1;
        if (bus.op_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Register 0 is hard-wired: acknowledge but suppress the strobe.
        wb_ready_c  = 1'b1;
        rf_addr_w_c = bus.wb_addr;
        rf_data_w_c = bus.wb_data;
        rf_write_c  = (bus.wb_addr != '0);
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.wb_ready   = wb_ready_c;
  assign bus.op_valid   = op_valid_c;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.rf_read    = rf_read_c;
  assign bus.rf_write   = rf_write_c;
  assign bus.rf_addr_r1 = rs_q;
  assign bus.rf_addr_r2 = rt_q;
  assign bus.rf_addr_w  = rf_addr_w_c;
  assign bus.rf_data_w  = rf_data_w_c;

endmodule
